param_mode_counter: RTL and testbench
=====================================

// Module: param_mode_counter
// PURPOSE
//   Parametrised up/down counter replacing the fixed 4-bit counter in the lab datapath.
//   Adds run-time count direction, synchronous load, an arbitrary modulus and three
//   count modes: wrap, saturate and one-shot.
//   Produces a terminal-count pulse and a sticky overflow flag for downstream timing logic.
// PARAMETERS
//   WIDTH      4    counter width in bits (2..32)
//   MAX_COUNT  15   highest count value; the count range is 0..MAX_COUNT (MAX_COUNT <= 2**WIDTH-1)
//   RST_VAL    0    count value applied at reset (must be <= MAX_COUNT)
// PORTS
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous reset, active-high
//   en          in   1      count enable; one step per cycle while high
//   up          in   1      1 = increment, 0 = decrement; sampled every cycle
//   mode        in   2      00 wrap, 01 saturate, 10 one-shot, 11 behaves as wrap
//   load        in   1      synchronous load of load_val
//   load_val    in   WIDTH  load value; values > MAX_COUNT are clamped to MAX_COUNT
//   start       in   1      arms a one-shot run (mode 10 only)
//   clr_ovf     in   1      clears ovf_sticky
//   count       out  WIDTH  registered count value
//   tc          out  1      registered one-cycle terminal-count pulse
//   busy        out  1      one-shot run in progress
//   ovf_sticky  out  1      sticky wrap/saturation flag
// BEHAVIOUR
//   - Reset: count=RST_VAL, tc=0, busy=0, ovf_sticky=0, FSM=IDLE. rst overrides all other inputs.
//   - Priority per edge: rst > load > start > en. load with en high: the load wins and no step occurs.
//   - Boundary: up boundary = MAX_COUNT, down boundary = 0. All arithmetic is modulo the range 0..MAX_COUNT.
//   - tc is 1 for exactly one cycle, coincident with the count value produced by a qualifying step.
//     In every other cycle tc is 0.
//   - Wrap mode (00/11): en at the boundary wraps the count (MAX->0 up, 0->MAX down).
//     This step qualifies for tc and sets ovf_sticky.
//   - Saturate mode (01): en at the boundary holds the count. This step qualifies for tc and
//     sets ovf_sticky. Holding at the boundary with en held high pulses tc on every such cycle.
//   - One-shot mode (10), two-state FSM:
//       IDLE: busy=0, count holds and en is ignored.
//             start -> count = 0 (up) or MAX_COUNT (down), go to RUN.
//       RUN:  busy=1, en steps the count.
//             A step that reaches the boundary -> tc, go to IDLE. ovf_sticky is unaffected.
//             start in RUN is ignored. load in RUN loads the count and stays in RUN.
//             A load of the current boundary value does not end the run; the next en step past
//             it wraps and ends the run with tc.
//   - A mode change away from 10 forces the FSM to IDLE (busy=0) on that edge. The count is kept.
//   - A change of up during RUN is honoured at once; the boundary is re-evaluated every cycle.
//   - ovf_sticky: a set and clr_ovf on the same edge -> set wins (stays 1).
//   - Zero latency from inputs to next state: count, tc and busy all update on the same edge.
// CONFIGURATION
//   GRAY_OUT_EN defined: adds output count_gray [WIDTH], which is count converted to Gray code
//     and registered, updating on the same edge as count. Reset value is the Gray code of RST_VAL.
//     Used for clock-domain crossing of the count.
//   GRAY_OUT_EN undefined: the port and its logic are absent, and all other behaviour is identical.
// TESTING  (WIDTH=4, MAX_COUNT=9, RST_VAL=0)
//   - rst high for 3 edges, then wrap mode with up=1 and en=1 for 12 cycles
//       -> count 1..9,0,1,2; tc high only in the cycle count=0; ovf_sticky=1 from that cycle.
//   - Saturate mode, up=0, count=2, en=1 for 5 cycles
//       -> count 1,0,0,0,0; tc high on the 3rd, 4th and 5th cycles; clr_ovf=1 then clears ovf_sticky.
//   - Load path: load=1 with load_val=13 and en=1
//       -> count=9, no step, tc=0; next edge (en=1, up=1, wrap mode) -> count=0, tc=1.
//   - One-shot mode, up=1: start pulse, then en=1
//       -> busy=1, count 0..9; tc=1 and busy=0 at count=9; further en leaves count at 9; start ignored while busy.
//   - Mid-operation events: one-shot RUN at count=5 with rst=1 -> count=0, busy=0, tc=0 next cycle.
//     Separately, at count=5 switch mode to 00 -> busy=0 and count continues 6,7...
//   - With GRAY_OUT_EN defined, count 0..9 -> count_gray 0,1,3,2,6,7,5,4,C,D on the same cycles as count.

Source files
------------

// File: rtl/param_mode_counter.sv
// param_mode_counter: parametrised up/down counter with run-time direction,
// synchronous clamped load, arbitrary modulus 0..MAX_COUNT and three modes
// (wrap, saturate, one-shot). Emits a registered terminal-count pulse and a
// sticky overflow flag.
// Optional feature macro GRAY_OUT_EN: adds a registered Gray-coded copy of
// the count (count_gray) for clock-domain crossing.
module param_mode_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 15,
  parameter int unsigned RST_VAL   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             ovf_sticky
`ifdef GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] count_gray
`endif
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             ovf_nxt;
  logic             at_bnd;
  logic [WIDTH-1:0] bnd_val;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] load_clamped;
  logic             oneshot;

  // Next-state decode: rst handled in the register, then load > start > en.
  always_comb begin
    oneshot      = (mode == 2'b10);
    bnd_val      = up ? MAX_V : '0;
    at_bnd       = (count == bnd_val);
    // Stepping from the boundary wraps to the opposite end of the range.
    stepped      = at_bnd ? (up ? '0 : MAX_V) : (up ? count + 1'b1 : count - 1'b1);
    load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
    count_nxt    = count;
    tc_nxt       = 1'b0;
    state_nxt    = state;
    ovf_nxt      = ovf_sticky & ~clr_ovf;

    if (load) begin
      count_nxt = load_clamped;
    end else if (oneshot && state == IDLE && start) begin
      count_nxt = up ? '0 : MAX_V;
      state_nxt = RUN;
    end else if (en) begin
      case (mode)
        2'b01: begin
          if (at_bnd) begin
            tc_nxt  = 1'b1;
            ovf_nxt = 1'b1;
          end else begin
            count_nxt = stepped;
          end
        end
        2'b10: begin
          if (state == RUN) begin
            count_nxt = stepped;
            // A run ends either by reaching the boundary or, after a load of the
            // boundary value, by wrapping past it.
            if (at_bnd || stepped == bnd_val) begin
              tc_nxt    = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        default: begin
          count_nxt = stepped;
          if (at_bnd) begin
            tc_nxt  = 1'b1;
            ovf_nxt = 1'b1;
          end
        end
      endcase
    end

    if (!oneshot) state_nxt = IDLE;
  end

  // State, count and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= RST_V;
      tc         <= 1'b0;
      busy       <= 1'b0;
      ovf_sticky <= 1'b0;
`ifdef GRAY_OUT_EN
      count_gray <= RST_V ^ (RST_V >> 1);
`endif
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      tc         <= tc_nxt;
      busy       <= (state_nxt == RUN);
      ovf_sticky <= ovf_nxt;
`ifdef GRAY_OUT_EN
      count_gray <= count_nxt ^ (count_nxt >> 1);
`endif
    end
  end

endmodule

// File: tb/tb_param_mode_counter.sv
// Directed self-checking bench for param_mode_counter (WIDTH=4, MAX_COUNT=9).
module tb_param_mode_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load, start, clr_ovf;
  logic [1:0] mode;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       tc, busy, ovf_sticky;
`ifdef GRAY_OUT_EN
  logic [3:0] count_gray;
`endif

  int checks = 0;
  int errors = 0;

  param_mode_counter #(.WIDTH(4), .MAX_COUNT(9), .RST_VAL(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .up         (up),
    .mode       (mode),
    .load       (load),
    .load_val   (load_val),
    .start      (start),
    .clr_ovf    (clr_ovf),
    .count      (count),
    .tc         (tc),
    .busy       (busy),
    .ovf_sticky (ovf_sticky)
`ifdef GRAY_OUT_EN
    ,
    .count_gray (count_gray)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge, then check all outputs 1 time unit later.
  task automatic step(input string tag, input int e_cnt, input int e_tc,
                      input int e_busy, input int e_ovf);
    @(posedge clk);
    #1;
    check({tag, ".count"}, int'(count), e_cnt);
    check({tag, ".tc"},    int'(tc),    e_tc);
    check({tag, ".busy"},  int'(busy),  e_busy);
    check({tag, ".ovf"},   int'(ovf_sticky), e_ovf);
`ifdef GRAY_OUT_EN
    check({tag, ".gray"}, int'(count_gray), e_cnt ^ (e_cnt >> 1));
`endif
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; start = 1'b0;
    clr_ovf = 1'b0; mode = 2'b00; load_val = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.count", int'(count), 0);
    check("reset.tc", int'(tc), 0);
    check("reset.busy", int'(busy), 0);
    check("reset.ovf", int'(ovf_sticky), 0);

    // Wrap up: 1..9,0,1,2 with tc only at the wrap, ovf from then on.
    rst = 1'b0; en = 1'b1;
    for (int i = 1; i <= 12; i++)
      step("wrap", i % 10, (i == 10) ? 1 : 0, 0, (i >= 10) ? 1 : 0);

    // Saturate down from 2.
    mode = 2'b01; up = 1'b0;
    step("sat1", 1, 0, 0, 1);
    step("sat2", 0, 0, 0, 1);
    step("sat3", 0, 1, 0, 1);
    clr_ovf = 1'b1;                        // set and clear together: set wins
    step("sat4", 0, 1, 0, 1);
    clr_ovf = 1'b0;
    step("sat5", 0, 1, 0, 1);
    en = 1'b0; clr_ovf = 1'b1;
    step("clr", 0, 0, 0, 0);
    clr_ovf = 1'b0;

    // Load wins over en and clamps 13 to 9; then wrap up.
    mode = 2'b00; up = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd13;
    step("load", 9, 0, 0, 0);
    load = 1'b0;
    step("load_wrap", 0, 1, 0, 1);
    en = 1'b0; clr_ovf = 1'b1;
    step("clr2", 0, 0, 0, 0);
    clr_ovf = 1'b0;

    // One-shot: idle ignores en, start arms, run to 9, start ignored in RUN.
    mode = 2'b10; en = 1'b1;
    step("os_idle", 0, 0, 0, 0);
    en = 1'b0; start = 1'b1;
    step("os_start", 0, 0, 1, 0);
    start = 1'b0; en = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      start = (i == 3);
      step("os_run", i, (i == 9) ? 1 : 0, (i == 9) ? 0 : 1, 0);
    end
    start = 1'b0;
    step("os_done", 9, 0, 0, 0);

    // Reset in the middle of a run.
    en = 1'b0; start = 1'b1;
    step("os2_start", 0, 0, 1, 0);
    start = 1'b0; en = 1'b1;
    for (int i = 1; i <= 5; i++) step("os2_run", i, 0, 1, 0);
    rst = 1'b1;
    step("os2_rst", 0, 0, 0, 0);
    rst = 1'b0;

    // Mode change away from one-shot drops busy, count continues.
    en = 1'b0; start = 1'b1;
    step("os3_start", 0, 0, 1, 0);
    start = 1'b0; en = 1'b1;
    for (int i = 1; i <= 5; i++) step("os3_run", i, 0, 1, 0);
    mode = 2'b00;
    step("mode_sw6", 6, 0, 0, 0);
    step("mode_sw7", 7, 0, 0, 0);

    // Load of the boundary during RUN keeps running; next step wraps and ends it.
    mode = 2'b10; en = 1'b0; start = 1'b1;
    step("os4_start", 0, 0, 1, 0);
    start = 1'b0; load = 1'b1; load_val = 4'd9;
    step("os4_load", 9, 0, 1, 0);
    load = 1'b0; en = 1'b1;
    step("os4_wrap", 0, 1, 0, 0);

    // One-shot down: start lands on MAX_COUNT.
    en = 1'b0; up = 1'b0; start = 1'b1;
    step("os5_start", 9, 0, 1, 0);
    start = 1'b0; en = 1'b1;
    step("os5_step", 8, 0, 1, 0);

    // Mode 11 behaves as wrap (down from 8 wraps at 0).
    mode = 2'b11;
    for (int i = 7; i >= 0; i--) step("m11", i, 0, 0, 0);
    step("m11_wrap", 9, 1, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
